// File: rtl/serial_mag_comparator.sv
// Bit-serial WIDTH-bit magnitude comparator: accepts one A/B bit pair per
// transfer and presents registered GT/EQ/LT with a one-cycle done pulse.
module serial_mag_comparator #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  localparam int  CNT_W     = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_valid,
  input  logic             A_bit,
  input  logic             B_bit,
  output logic             bit_ready,
  output logic             busy,
  output logic             done,
  output logic             result_valid,
  output logic             GT,
  output logic             EQ,
  output logic             LT,
  output logic [CNT_W-1:0] bit_count
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state;
  logic   gt, lt;
  logic   nxt_gt, nxt_lt;
  logic   transfer;
  logic   last_bit;

  assign transfer = bit_valid && bit_ready;
  assign last_bit = (bit_count == CNT_W'(WIDTH - 1));

  // Flag update for the bit pair on the inputs this cycle.
  always_comb begin
    // NOTE: defaults first so every path assigns both flags and no latch is inferred.
    nxt_gt = gt;
    nxt_lt = lt;
    if (MSB_FIRST) begin
      // First differing bit is the most significant one, so it locks the result.
      if (!gt && !lt) begin
        if (A_bit && !B_bit)      nxt_gt = 1'b1;
        else if (!A_bit && B_bit) nxt_lt = 1'b1;
      end
    end else begin
      // Each later differing bit outweighs everything seen before it.
      if (A_bit && !B_bit) begin
        nxt_gt = 1'b1;
        nxt_lt = 1'b0;
      end else if (!A_bit && B_bit) begin
        nxt_gt = 1'b0;
        nxt_lt = 1'b1;
      end
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_ready    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      GT           <= 1'b0;
      EQ           <= 1'b0;
      LT           <= 1'b0;
      bit_count    <= '0;
      gt           <= 1'b0;
      lt           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= SHIFT;
            busy         <= 1'b1;
            bit_ready    <= 1'b1;
            bit_count    <= '0;
            gt           <= 1'b0;
            lt           <= 1'b0;
            result_valid <= 1'b0;
            GT           <= 1'b0;
            EQ           <= 1'b0;
            LT           <= 1'b0;
          end
        end
        SHIFT: begin
          // Abort wins even over the final transfer; the bit pair is dropped.
          if (abort) begin
            state        <= IDLE;
            busy         <= 1'b0;
            bit_ready    <= 1'b0;
            result_valid <= 1'b0;
            GT           <= 1'b0;
            EQ           <= 1'b0;
            LT           <= 1'b0;
            bit_count    <= '0;
          end else if (transfer) begin
            gt        <= nxt_gt;
            lt        <= nxt_lt;
            bit_count <= bit_count + CNT_W'(1);
            if (last_bit) begin
              state        <= IDLE;
              busy         <= 1'b0;
              bit_ready    <= 1'b0;
              done         <= 1'b1;
              result_valid <= 1'b1;
              GT           <= nxt_gt;
              LT           <= nxt_lt;
              EQ           <= ~(nxt_gt | nxt_lt);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Drives an MSB-first and an LSB-first 8-bit comparator with the same operand
// words (bit order adapted per instance) and compares against hand-computed results.
module tb_serial_mag_comparator;

  localparam int W  = 8;
  localparam int CW = $clog2(W) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, bit_valid = 1'b0;
  logic a_m = 1'b0, b_m = 1'b0, a_l = 1'b0, b_l = 1'b0;

  logic ready_m, busy_m, done_m, rv_m, gt_m, eq_m, lt_m;
  logic ready_l, busy_l, done_l, rv_l, gt_l, eq_l, lt_l;
  logic [CW-1:0] cnt_m, cnt_l;

  serial_mag_comparator #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .bit_valid(bit_valid), .A_bit(a_m), .B_bit(b_m),
    .bit_ready(ready_m), .busy(busy_m), .done(done_m), .result_valid(rv_m),
    .GT(gt_m), .EQ(eq_m), .LT(lt_m), .bit_count(cnt_m));

  serial_mag_comparator #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .bit_valid(bit_valid), .A_bit(a_l), .B_bit(b_l),
    .bit_ready(ready_l), .busy(busy_l), .done(done_l), .result_valid(rv_l),
    .GT(gt_l), .EQ(eq_l), .LT(lt_l), .bit_count(cnt_l));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_seen_m = 0;
  int done_seen_l = 0;
  int exp_done = 0;

  always @(negedge clk) begin
    if (done_m === 1'b1) done_seen_m++;
    if (done_l === 1'b1) done_seen_l++;
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       gt;
    logic       eq;
    logic       lt;
    int         gap_a;
    int         gap_b;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check2(input string name, input logic [31:0] act_m,
                        input logic [31:0] act_l, input logic [31:0] exp);
    check({name, "/msb"}, act_m, exp);
    check({name, "/lsb"}, act_l, exp);
  endtask

  task automatic check_outputs(input string name, input logic busy, input logic ready,
                               input logic dn, input logic rv, input logic gt,
                               input logic eq, input logic lt, input int cnt);
    check2({name, ".busy"},  32'(busy_m),  32'(busy_l),  32'(busy));
    check2({name, ".ready"}, 32'(ready_m), 32'(ready_l), 32'(ready));
    check2({name, ".done"},  32'(done_m),  32'(done_l),  32'(dn));
    check2({name, ".rv"},    32'(rv_m),    32'(rv_l),    32'(rv));
    check2({name, ".GT"},    32'(gt_m),    32'(gt_l),    32'(gt));
    check2({name, ".EQ"},    32'(eq_m),    32'(eq_l),    32'(eq));
    check2({name, ".LT"},    32'(lt_m),    32'(lt_l),    32'(lt));
    check2({name, ".cnt"},   32'(cnt_m),   32'(cnt_l),   32'(cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_op(input string name);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_outputs({name, ".start"}, 1, 1, 0, 0, 0, 0, 0, 0);
  endtask

  // Bit i of the stream: MSB-first instance sees word bit W-1-i, LSB-first sees bit i.
  task automatic send_bit(input logic [7:0] a, input logic [7:0] b, input int i);
    bit_valid = 1'b1;
    a_m = a[W-1-i];
    b_m = b[W-1-i];
    a_l = a[i];
    b_l = b[i];
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic run_op(input string name, input vec_t v);
    begin_op(name);
    for (int i = 0; i < W; i++) begin
      send_bit(v.a, v.b, i);
      if (i < W - 1) begin
        check2({name, ".mid_busy"}, 32'(busy_m), 32'(busy_l), 32'd1);
        if (i == v.gap_a || i == v.gap_b) begin
          repeat (3) tick();
          check2({name, ".gap_cnt"}, 32'(cnt_m), 32'(cnt_l), 32'(i + 1));
          check2({name, ".gap_done"}, 32'(done_m), 32'(done_l), 32'd0);
        end
      end
    end
    check_outputs({name, ".result"}, 0, 0, 1, 1, v.gt, v.eq, v.lt, W);
    exp_done++;
    tick();
    check_outputs({name, ".hold"}, 0, 0, 0, 1, v.gt, v.eq, v.lt, W);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, -1, -1};
    vecs[1] = '{8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0,  1,  4};
    vecs[2] = '{8'h01, 8'h02, 1'b0, 1'b0, 1'b1, -1, -1};
    vecs[3] = '{8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, -1, -1};
    vecs[4] = '{8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, -1, -1};
    vecs[5] = '{8'h7F, 8'h80, 1'b0, 1'b0, 1'b1, -1, -1};
    vecs[6] = '{8'h81, 8'h18, 1'b1, 1'b0, 1'b0,  3, -1};
    vecs[7] = '{8'h3C, 8'h3D, 1'b0, 1'b0, 1'b1, -1, -1};

    // Reset and idle behaviour.
    repeat (2) tick();
    check_outputs("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1;
      a_m = 1'b1; a_l = 1'b1;
      tick();
      bit_valid = 1'b0;
      tick();
    end
    check_outputs("idle_valid", 0, 0, 0, 0, 0, 0, 0, 0);

    // Abort in IDLE does nothing.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_outputs("idle_abort", 0, 0, 0, 0, 0, 0, 0, 0);

    // Table-driven full operations.
    for (int v = 0; v < 8; v++) run_op($sformatf("vec%0d", v), vecs[v]);

    // Start during SHIFT is ignored; abort at bit 6 cancels without done.
    begin_op("abort_op");
    for (int i = 0; i < 3; i++) send_bit(8'h0F, 8'hF0, i);
    start = 1'b1;
    send_bit(8'h0F, 8'hF0, 3);
    start = 1'b0;
    check_outputs("start_in_shift", 1, 1, 0, 0, 0, 0, 0, 4);
    send_bit(8'h0F, 8'hF0, 4);
    check2("abort_pre.cnt", 32'(cnt_m), 32'(cnt_l), 32'd5);
    abort = 1'b1;
    send_bit(8'h0F, 8'hF0, 5);
    abort = 1'b0;
    check_outputs("abort", 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    check_outputs("abort_after", 0, 0, 0, 0, 0, 0, 0, 0);
    run_op("after_abort", vecs[3]);

    // Abort on the final transfer beats completion.
    begin_op("abort_last");
    for (int i = 0; i < W - 1; i++) send_bit(8'h12, 8'h34, i);
    abort = 1'b1;
    send_bit(8'h12, 8'h34, W - 1);
    abort = 1'b0;
    check_outputs("abort_last", 0, 0, 0, 0, 0, 0, 0, 0);

    // Start in the done cycle, then asynchronous reset at bit 3.
    begin_op("back2back");
    for (int i = 0; i < W; i++) send_bit(8'h80, 8'h7F, i);
    check_outputs("b2b_done", 0, 0, 1, 1, 1, 0, 0, W);
    exp_done++;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_outputs("b2b_restart", 1, 1, 0, 0, 0, 0, 0, 0);
    send_bit(8'hC3, 8'h3C, 0);
    send_bit(8'hC3, 8'hC3, 1);
    bit_valid = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check_outputs("async_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    bit_valid = 1'b0;
    repeat (3) tick();
    check_outputs("post_reset", 0, 0, 0, 0, 0, 0, 0, 0);

    check2("done_pulse_count", 32'(done_seen_m), 32'(done_seen_l), 32'(exp_done));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_mag_comparator.md
Name: serial_mag_comparator

Overview:
- Bit-serial N-bit magnitude comparator. Consumes one A/B bit pair per accepted transfer, WIDTH transfers per operation, then presents registered GT/EQ/LT plus a one-cycle done pulse.
- Sequential counterpart to the combinational 1-bit comparator. Sits between bit-serial producers (shift-register or serial-link front ends) and control logic that needs a full-word compare.

Parameters:
- WIDTH, 8, bits per operand; legal range 1..64.
- MSB_FIRST, 1, 1 = bits arrive MSB first, 0 = bits arrive LSB first.
- CNT_W (localparam), $clog2(WIDTH)+1, width of bit_count.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a new operation; honoured only in IDLE.
- abort  input  1  synchronous cancel of an in-progress operation.
- bit_valid  input  1  A_bit/B_bit are valid this cycle.
- A_bit  input  1  current operand-A bit.
- B_bit  input  1  current operand-B bit.
- bit_ready  output  1  block accepts a bit pair this cycle.
- busy  output  1  operation in progress (state SHIFT).
- done  output  1  one-cycle pulse; result just became valid.
- result_valid  output  1  GT/EQ/LT hold a completed result.
- GT  output  1  A > B.
- EQ  output  1  A == B.
- LT  output  1  A < B.
- bit_count  output  CNT_W  bit pairs accepted in the current operation.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE.
  - All outputs 0: bit_ready, busy, done, result_valid, GT, EQ, LT, bit_count.
  - Internal gt/lt flags 0.
- States: IDLE and SHIFT. All outputs are registered.
- IDLE, start=1: at the next edge:
  - state=SHIFT; busy=1; bit_ready=1.
  - bit_count=0; internal gt=lt=0.
  - result_valid=0; GT=EQ=LT=0.
- IDLE, start=0: bit_valid is ignored and nothing changes. Previous result and result_valid are held.
- SHIFT, start: ignored; does not restart.
- Transfer: occurs when bit_valid && bit_ready. bit_valid may drop for any number of cycles; state is held with no timeout.
- MSB_FIRST=1: first differing bit decides; later bits are ignored.
  - If gt=lt=0: A_bit&~B_bit sets gt; ~A_bit&B_bit sets lt; equal bits change nothing.
- MSB_FIRST=0: last differing bit decides.
  - A_bit&~B_bit gives gt=1, lt=0.
  - ~A_bit&B_bit gives lt=1, gt=0.
  - Equal bits hold the flags.
- Each transfer increments bit_count.
- Final transfer (bit_count==WIDTH-1): at that edge:
  - state=IDLE; busy=0; bit_ready=0.
  - done=1 for exactly one cycle; result_valid=1.
  - GT=final gt; LT=final lt; EQ=~(gt|lt), with the final bit pair included.
  - bit_count=WIDTH, held until the next start.
- Latency: result visible the cycle after the edge that captures the last bit.
- Invariant: when result_valid=1, exactly one of GT/EQ/LT is 1. When result_valid=0, all three are 0.
- start while done=1 (state already IDLE): accepted. Next cycle done=0, result_valid=0, busy=1.
- abort in SHIFT: at the next edge:
  - state=IDLE; busy=0; bit_ready=0.
  - done stays 0; result_valid=0; GT=EQ=LT=0; bit_count=0.
  - A transfer in the same cycle is discarded.
  - abort has priority over completion when both occur on the final transfer.
- abort in IDLE: no effect.
- Reset mid-operation: immediate return to reset values; no done.
- WIDTH=1: a single transfer completes the operation; behaves as a registered 1-bit comparator.

Test Plan:
- Reset: hold rst_n=0, then release → all outputs 0; bit_valid pulses in IDLE leave bit_count=0.
- MSB_FIRST=1, WIDTH=8, A=8'h80, B=8'h7F streamed MSB first with no gaps → done high on the cycle after transfer 8; GT=1, EQ=0, LT=0; bit_count=8.
- MSB_FIRST=1, A=B=8'hA5, with bit_valid low for 3 cycles after bits 2 and 5 → completes after exactly 8 transfers; EQ=1; done is a single cycle.
- MSB_FIRST=0, A=8'h01, B=8'h02 streamed LSB first → LT=1, GT=0, EQ=0.
- start asserted during SHIFT at bit 4, then abort asserted at bit 6 → start has no effect; abort gives busy=0, result_valid=0, no done. A following start with A=8'hFF, B=8'h00 → GT=1.
- start asserted in the done cycle; rst_n pulsed low at bit 3 of that second operation → second operation starts immediately (done=0, busy=1 next cycle); reset clears all outputs asynchronously and no done pulse follows.
